// File: rtl/dm_wr_arb.sv
`default_nettype none
// ============================================================================
// Module   : dm_wr_arb
// Brief    : Round-robin N-channel write-command arbiter feeding one datamover
//            S2MM command/data port.
// Revision : 1.0 - initial release
// ============================================================================
module dm_wr_arb #(
  parameter int CH_NUM     = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int DATA_WIDTH = 64
) (
  input  logic                                       clk,
  input  logic                                       rstn,
  input  logic [CH_NUM-1:0]                          ch_req,
  input  logic [CH_NUM*ADDR_WIDTH-1:0]               ch_addr,
  input  logic [CH_NUM*LEN_WIDTH-1:0]                ch_len,
  input  logic [CH_NUM-1:0]                          ch_wvld,
  input  logic [CH_NUM*DATA_WIDTH-1:0]               ch_wdata,
  output logic [CH_NUM-1:0]                          ch_wrdy,
  output logic [CH_NUM-1:0]                          ch_done,
  output logic [CH_NUM-1:0]                          ch_err,
  input  logic                                       wready,
  output logic                                       wstart,
  output logic [ADDR_WIDTH-1:0]                      waddr,
  output logic [LEN_WIDTH-1:0]                       wdata_len,
  output logic                                       wdata_vld,
  output logic [DATA_WIDTH-1:0]                      wdata,
  output logic                                       busy,
  output logic [((CH_NUM > 1) ? $clog2(CH_NUM) : 1)-1:0] cur_ch
);

  localparam int c_ch_w  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int c_bytes = DATA_WIDTH / 8;
  localparam int c_shift = $clog2(c_bytes);
  localparam int c_bw    = LEN_WIDTH + 1;
  localparam logic [c_bw-1:0]   c_round    = c_bw'(c_bytes - 1);
  localparam logic [c_bw-1:0]   c_beat_one = c_bw'(1);
  localparam logic [c_ch_w-1:0] c_ch_one   = c_ch_w'(1);
  localparam logic [c_ch_w-1:0] c_ch_last  = c_ch_w'(CH_NUM - 1);
  localparam logic [c_ch_w:0]   c_ch_num   = (c_ch_w + 1)'(CH_NUM);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMD  = 3'd1,
    S_DATA = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic [c_ch_w-1:0]       r_ptr, r_cur_ch, w_off, w_sel_idx, w_cur_nxt;
  logic [c_ch_w:0]         w_sum;
  logic [2*CH_NUM-1:0]     w_req_dbl;
  logic [CH_NUM-1:0]       w_req_rot, w_cur_oh;
  logic                    w_sel_vld, w_grant, w_accept;
  logic [ADDR_WIDTH-1:0]   w_sel_addr;
  logic [LEN_WIDTH-1:0]    w_sel_len;
  logic [c_bw-1:0]         w_sel_beats, r_beats, w_beats_nxt;

  logic [CH_NUM-1:0]       r_wrdy, r_done, r_err;
  logic                    r_wstart, r_wvld, r_busy;
  logic [ADDR_WIDTH-1:0]   r_waddr;
  logic [LEN_WIDTH-1:0]    r_wlen;
  logic [DATA_WIDTH-1:0]   r_wdata;

  // Rotate requests so bit 0 is the channel the round-robin search starts at.
  assign w_req_dbl = {ch_req, ch_req};
  assign w_req_rot = w_req_dbl[r_ptr +: CH_NUM];
  assign w_sel_vld = |ch_req;

  always_comb begin
    w_off = '0;
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      if (w_req_rot[i]) w_off = c_ch_w'(i);
    end
    w_sum     = {1'b0, r_ptr} + {1'b0, w_off};
    w_sel_idx = (w_sum >= c_ch_num) ? c_ch_w'(w_sum - c_ch_num) : w_sum[c_ch_w-1:0];
  end

  assign w_sel_addr  = ch_addr[w_sel_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_sel_len   = ch_len[w_sel_idx*LEN_WIDTH +: LEN_WIDTH];
  // One extra bit keeps the round-up from wrapping at the maximum length.
  assign w_sel_beats = ({1'b0, w_sel_len} + c_round) >> c_shift;
  assign w_accept    = (r_state == S_DATA) && ch_wvld[r_cur_ch] && r_wrdy[r_cur_ch];

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_sel_vld && wready) begin
          w_grant     = 1'b1;
          w_state_nxt = (w_sel_len == '0) ? S_ERR : S_CMD;
        end
      end
      S_CMD:   w_state_nxt = S_DATA;
      S_DATA:  if (w_accept && (r_beats == c_beat_one)) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      S_ERR:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_cur_nxt   = w_grant ? w_sel_idx : r_cur_ch;
    w_beats_nxt = r_beats;
    if (w_grant)       w_beats_nxt = w_sel_beats;
    else if (w_accept) w_beats_nxt = r_beats - c_beat_one;
    w_cur_oh            = '0;
    w_cur_oh[w_cur_nxt] = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= S_IDLE;
      r_ptr    <= '0;
      r_cur_ch <= '0;
      r_beats  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cur_ch <= w_cur_nxt;
      r_beats  <= w_beats_nxt;
      if ((r_state == S_DONE) || (r_state == S_ERR))
        r_ptr <= (r_cur_ch == c_ch_last) ? '0 : r_cur_ch + c_ch_one;
    end
  end

  // Every port is driven from a flop; each is computed from the next state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wrdy   <= '0;
      r_done   <= '0;
      r_err    <= '0;
      r_wstart <= 1'b0;
      r_waddr  <= '0;
      r_wlen   <= '0;
      r_wvld   <= 1'b0;
      r_wdata  <= '0;
      r_busy   <= 1'b0;
    end else begin
      r_wrdy   <= ((w_state_nxt == S_DATA) && (w_beats_nxt != '0)) ? w_cur_oh : '0;
      r_done   <= (w_state_nxt == S_DONE) ? w_cur_oh : '0;
      r_err    <= (w_state_nxt == S_ERR) ? w_cur_oh : '0;
      r_wstart <= (w_state_nxt == S_CMD);
      r_waddr  <= (w_state_nxt == S_CMD) ? w_sel_addr : '0;
      r_wlen   <= (w_state_nxt == S_CMD) ? w_sel_len : '0;
      r_wvld   <= w_accept;
      if (w_accept) r_wdata <= ch_wdata[r_cur_ch*DATA_WIDTH +: DATA_WIDTH];
      r_busy   <= (w_state_nxt != S_IDLE);
    end
  end

  assign ch_wrdy   = r_wrdy;
  assign ch_done   = r_done;
  assign ch_err    = r_err;
  assign wstart    = r_wstart;
  assign waddr     = r_waddr;
  assign wdata_len = r_wlen;
  assign wdata_vld = r_wvld;
  assign wdata     = r_wdata;
  assign busy      = r_busy;
  assign cur_ch    = r_cur_ch;

endmodule
`default_nettype wire

// File: tb/tb_dm_wr_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_dm_wr_arb
// Brief    : Scoreboard bench for dm_wr_arb with directed transfers.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dm_wr_arb;
  localparam int CH = 4;
  localparam int AW = 32;
  localparam int LW = 16;
  localparam int DW = 64;

  logic            clk = 1'b0;
  logic            rstn;
  logic [CH-1:0]   ch_req, ch_wvld, ch_wrdy, ch_done, ch_err;
  logic [CH*AW-1:0] ch_addr;
  logic [CH*LW-1:0] ch_len;
  logic [CH*DW-1:0] ch_wdata;
  logic            wready, wstart, wdata_vld, busy;
  logic [AW-1:0]   waddr;
  logic [LW-1:0]   wdata_len;
  logic [DW-1:0]   wdata;
  logic [1:0]      cur_ch;

  dm_wr_arb #(.CH_NUM(CH), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rstn(rstn), .ch_req(ch_req), .ch_addr(ch_addr), .ch_len(ch_len),
    .ch_wvld(ch_wvld), .ch_wdata(ch_wdata), .ch_wrdy(ch_wrdy), .ch_done(ch_done),
    .ch_err(ch_err), .wready(wready), .wstart(wstart), .waddr(waddr),
    .wdata_len(wdata_len), .wdata_vld(wdata_vld), .wdata(wdata), .busy(busy),
    .cur_ch(cur_ch)
  );

  always #2 clk = ~clk;

  logic [63:0] exp_cmd[$];
  logic [63:0] exp_beat[$];
  logic [7:0]  exp_evt[$];
  int          n_pass = 0;
  int          n_total = 0;
  int          wstart_cnt = 0;
  logic [CH-1:0] wrdy_seen = '0;
  int          src_cnt[CH];
  int          src_idx[CH];
  bit          src_tog[CH];
  logic [CH-1:0] rdy_q = '0;
  bit          phase = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
  endtask

  task automatic unexpected(input string name);
    n_total++;
    $display("FAIL %s: actual=event required=none", name);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_src();
    for (int i = 0; i < CH; i++) begin
      src_cnt[i] = 0; src_idx[i] = 0; src_tog[i] = 1'b0;
    end
  endtask

  // Queue the expected command, beats and completion, then raise the request.
  task automatic xfer(input int ch, input logic [31:0] addr, input logic [15:0] len,
                      input int nbeats, input int nsrc, input bit tog);
    if (len != 16'd0) exp_cmd.push_back({14'd0, 2'(ch), addr, len});
    for (int k = 0; k < nbeats; k++) exp_beat.push_back(64'(ch * 256 + k));
    exp_evt.push_back(((len == 16'd0) ? 8'h80 : 8'h00) | 8'(ch));
    src_idx[ch] = 0; src_cnt[ch] = nsrc; src_tog[ch] = tog;
    ch_addr[ch*AW +: AW] = addr;
    ch_len[ch*LW +: LW]  = len;
    ch_req[ch]           = 1'b1;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((exp_cmd.size() + exp_beat.size() + exp_evt.size()) != 0 && n < budget) begin
      step(); n++;
    end
    if ((exp_cmd.size() + exp_beat.size() + exp_evt.size()) != 0) begin
      n_total++;
      $display("FAIL %s_timeout: actual=%0d pending required=0", tag,
               exp_cmd.size() + exp_beat.size() + exp_evt.size());
    end
  endtask

  task automatic wait_src(input string tag, input int ch, input int n, input int budget);
    int k = 0;
    while (src_idx[ch] < n && k < budget) begin step(); k++; end
    if (src_idx[ch] < n) begin
      n_total++;
      $display("FAIL %s_timeout: actual=%0d beats required=%0d", tag, src_idx[ch], n);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctrl"}, 64'({ch_wrdy, ch_done, ch_err, wstart, wdata_vld, busy, cur_ch}), 64'd0);
    chk({tag, "_cmd"}, {16'd0, waddr, wdata_len}, 64'd0);
    chk({tag, "_wdata"}, wdata, 64'd0);
  endtask

  // Producer model: advances a channel's beat index on each accepted handshake.
  initial begin : drv
    ch_wvld  = '0;
    ch_wdata = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < CH; i++)
        if (ch_wvld[i] && rdy_q[i]) src_idx[i]++;
      phase = ~phase;
      for (int i = 0; i < CH; i++) begin
        ch_wvld[i] = (src_idx[i] < src_cnt[i]) && (!src_tog[i] || phase);
        ch_wdata[i*DW +: DW] = 64'(i * 256 + src_idx[i]);
      end
      rdy_q = ch_wrdy;
    end
  end

  initial begin : mon
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (ch_wrdy != '0) begin
          wrdy_seen = wrdy_seen | ch_wrdy;
          chk("wrdy_onehot", 64'($onehot(ch_wrdy)), 64'd1);
        end
        if (wstart) begin
          wstart_cnt++;
          if (exp_cmd.size() == 0) unexpected("cmd_unexpected");
          else chk("cmd", {14'd0, cur_ch, waddr, wdata_len}, exp_cmd.pop_front());
        end
        if (wdata_vld) begin
          if (exp_beat.size() == 0) unexpected("beat_unexpected");
          else chk("beat", wdata, exp_beat.pop_front());
        end
        for (int i = 0; i < CH; i++) begin
          if (ch_done[i] || ch_err[i]) begin
            ch_req[i] = 1'b0;
            if (exp_evt.size() == 0) unexpected("evt_unexpected");
            else chk("evt", 64'((ch_err[i] ? 8'h80 : 8'h00) | 8'(i)), 64'(exp_evt.pop_front()));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int snap;
    rstn = 1'b0; ch_req = '0; ch_addr = '0; ch_len = '0; wready = 1'b1;
    clear_src();
    repeat (3) step();
    check_zero("reset");
    rstn = 1'b1;
    step();

    // Single channel, 8 beats.
    xfer(0, 32'h1000, 16'd64, 8, 8, 1'b0);
    step();
    chk("t1_wstart_latency", 64'(wstart), 64'd1);
    wait_idle("t1", 200);
    step();
    chk("t1_busy_idle", 64'(busy), 64'd0);

    // len 13 -> 2 beats although the producer offers 4.
    xfer(1, 32'h3000, 16'd13, 2, 4, 1'b0);
    wait_src("t2", 1, 2, 100);
    chk("t2_wrdy_low", 64'(ch_wrdy), 64'd0);
    wait_idle("t2", 100);
    chk("t2_beats_pulled", 64'(src_idx[1]), 64'd2);
    src_cnt[1] = 0;

    // Fresh reset, then round-robin across all channels.
    rstn = 1'b0; ch_req = '0; clear_src();
    repeat (2) step();
    rstn = 1'b1;
    step();
    for (int c = 0; c < CH; c++) xfer(c, 32'h2000 + 32'(c) * 32'h100, 16'd8, 1, 1, 1'b0);
    wait_idle("t3a", 200);
    xfer(0, 32'h2400, 16'd8, 1, 1, 1'b0);
    xfer(2, 32'h2600, 16'd8, 1, 1, 1'b0);
    wait_idle("t3b", 200);

    // Command backpressure, then a toggling producer.
    wready = 1'b0;
    snap = wstart_cnt;
    xfer(1, 32'h4000, 16'd32, 4, 4, 1'b1);
    repeat (10) step();
    chk("t4_no_wstart", 64'(wstart_cnt - snap), 64'd0);
    chk("t4_busy_low", 64'(busy), 64'd0);
    wready = 1'b1;
    step();
    chk("t4_wstart_after_wready", 64'(wstart), 64'd1);
    wait_idle("t4", 200);
    chk("t4_beats_pulled", 64'(src_idx[1]), 64'd4);

    // Zero length on ch2 with ch3 pending behind it.
    wrdy_seen = '0;
    xfer(2, 32'h5000, 16'd0, 0, 0, 1'b0);
    xfer(3, 32'h5300, 16'd16, 2, 2, 1'b0);
    wait_idle("t5", 200);
    chk("t5_no_wrdy_ch2", 64'(wrdy_seen[2]), 64'd0);

    // Move the pointer off zero, then abort a ch0 transfer mid-stream.
    xfer(1, 32'h6000, 16'd8, 1, 1, 1'b0);
    wait_idle("t6a", 100);
    xfer(0, 32'h7000, 16'd64, 8, 8, 1'b0);
    wait_src("t6", 0, 3, 100);
    rstn = 1'b0;
    #1;
    check_zero("abort");
    exp_cmd.delete(); exp_beat.delete(); exp_evt.delete();
    ch_req = '0;
    clear_src();
    repeat (3) step();
    rstn = 1'b1;
    step();
    xfer(0, 32'h8000, 16'd8, 1, 1, 1'b0);
    xfer(3, 32'h8300, 16'd8, 1, 1, 1'b0);
    wait_idle("t6b", 200);
    step();
    chk("end_busy_idle", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
